// File: rtl/mux_rr_arbiter_4.sv
// Round-robin arbiter for the shared 4:1 datapath mux: registers the winner,
// drives a one-hot grant and mux select, and enforces a per-owner hold limit.
module mux_rr_arbiter_4 #(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [3:0]         lock,
    input  logic [4*WIDTH-1:0] data_in,
    output logic [3:0]         gnt,
    output logic [1:0]         sel,
    output logic               gnt_valid,
    output logic [WIDTH-1:0]   data_out
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t       state;
    logic [1:0]   ptr;
    logic [7:0]   hold_cnt;

    logic [3:0]   others;
    logic         release_owner;
    logic [1:0]   idle_winner;
    logic [1:0]   handoff_winner;
    logic [WIDTH-1:0] words [4];

    // First set bit of r scanning upward from start, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (r[idx] && !found) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        others         = req & ~(4'b0001 << sel);
        release_owner  = ~req[sel] |
                         ((hold_cnt >= MAX_HOLD_C) && (others != 4'b0000) && ~lock[sel]);
        idle_winner    = rr_pick(req, ptr);
        handoff_winner = rr_pick(others, sel + 2'd1);
    end

    // Handoff on release goes straight to the next winner so the mux never idles
    // between owners; a lone owner keeps the grant with hold_cnt saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            sel       <= 2'b00;
            gnt_valid <= 1'b0;
            ptr       <= 2'b00;
            hold_cnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 4'b0000) begin
                        state     <= GRANT;
                        sel       <= idle_winner;
                        gnt       <= 4'b0001 << idle_winner;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= 8'd1;
                    end
                end
                GRANT: begin
                    if (release_owner) begin
                        ptr <= sel + 2'd1;
                        if (others != 4'b0000) begin
                            sel      <= handoff_winner;
                            gnt      <= 4'b0001 << handoff_winner;
                            hold_cnt <= 8'd1;
                        end else begin
                            state     <= IDLE;
                            gnt       <= 4'b0000;
                            gnt_valid <= 1'b0;
                        end
                    end else if (hold_cnt < MAX_HOLD_C) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_words
        assign words[i] = data_in[i*WIDTH +: WIDTH];
    end

    always_comb begin
        data_out = '0;
        if (gnt_valid) data_out = words[sel];
    end

endmodule

// File: doc/mux_rr_arbiter_4.md
Name: mux_rr_arbiter_4

Overview:
Round-robin arbiter and sequencer for the shared 4:1 datapath mux in the MIPS-32 core. Four requesters contend for one downstream resource. The block registers the winner, drives the mux select and a one-hot grant, and presents the selected data word. A per-grant hold limit enforces fairness under contention; an owner lock can override that limit for atomic bursts.

Parameters:
WIDTH, 32, data word width per requester
MAX_HOLD, 4, maximum consecutive grant cycles while another requester is waiting (legal range 1..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  request, one bit per requester, level-sensitive
lock  input  4  per-requester lock; only lock[owner] is examined
data_in  input  4*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH]
gnt  output  4  one-hot grant, registered
sel  output  2  mux select (index of owner), registered
gnt_valid  output  1  a grant is active, registered
data_out  output  WIDTH  data_in[sel] when gnt_valid, else 0 (combinational from registered sel)

Behaviour:
- Clocking and reset: single clock. Asynchronous active-low reset on rst_n.
- Reset values: state=IDLE, gnt=4'b0000, sel=2'b00, gnt_valid=0, ptr=0, hold_cnt=0. data_out=0 while in reset.
- Internal state:
  - ptr (2b): highest-priority index for the next arbitration.
  - hold_cnt (8b): consecutive cycles granted to the current owner, saturating at MAX_HOLD.
- Arbitration function: winner = first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- FSM states: IDLE, GRANT.
- IDLE:
  - If req==0: stay in IDLE, outputs hold their reset values.
  - Else: on the next edge go to GRANT with sel=winner, gnt=1<<winner, gnt_valid=1, hold_cnt=1.
  - Latency is one cycle from req sampled high to gnt high.
- GRANT, owner o=sel. Let others = req with bit o masked. Conditions evaluated each edge:
  - release = ~req[o] OR (hold_cnt>=MAX_HOLD AND others!=0 AND ~lock[o]).
  - If release: ptr <= o+1 (mod 4).
    - If others!=0: re-arbitrate from o+1 and grant the winner on the same edge, with hold_cnt=1. There is no idle bubble between owners.
    - Else: go to IDLE; gnt=0, gnt_valid=0, sel holds its last value.
  - If not release: keep owner; hold_cnt <= min(hold_cnt+1, MAX_HOLD).
- Boundary conditions:
  - Sole requester: holds the grant indefinitely; hold_cnt saturates at MAX_HOLD and is never reset.
  - lock[o]=1: the hold limit is ignored. Release happens only when req[o] drops.
  - lock on a non-owner has no effect.
  - Owner drops req while others request: handoff occurs on the next edge.
  - MAX_HOLD=1 with all four requesting: grant rotates every cycle 0,1,2,3,0...
  - Request withdrawn before it is granted: that requester is never granted. The arbiter does not remember it.
  - Pointer wrap: 3+1 wraps to 0.
  - Reset mid-grant: outputs return to reset values immediately (asynchronous). The first grant after reset is decided with ptr=0.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - gnt[sel]==1 whenever gnt_valid is high.
- data_out: pure mux of data_in by sel, gated by gnt_valid. Adds no latency beyond sel.

Test Plan:
1. Reset/idle: rst_n=0 with req=4'b1111 → gnt=0, sel=0, gnt_valid=0, data_out=0. After rst_n rises with req=0 → outputs remain 0.
2. Single requester: req=4'b0100 for 10 cycles, data_in[2]=32'hDEAD_BEEF → one cycle later gnt=4'b0100, sel=2, data_out=32'hDEADBEEF. Grant holds all 10 cycles. After req=0 → next cycle gnt=0 and state IDLE.
3. Full contention with MAX_HOLD=4, req=4'b1111 held → owner sequence 0,1,2,3,0, each for exactly 4 cycles. No cycle has gnt_valid=0 after the first grant.
4. Early release: owner 1 granted, req=4'b1010 → req[1] drops after 2 cycles → next edge gnt=4'b1000, sel=3, hold_cnt=1.
5. Lock: owner 0 with lock[0]=1, req=4'b0011, MAX_HOLD=4 → grant stays on 0 for 12 cycles. After lock[0]=0 → gnt moves to 1 on the next edge.
6. Async reset mid-grant: pulse rst_n low between edges while gnt=4'b0010 → gnt=0 immediately. After release with req=4'b1010 → the first grant goes to requester 1 (ptr=0).
